// File: rtl/serial_adder_if.sv
// Request/result bundle between a requesting block and serial_adder_ctrl.
// The c_in signal exists only when SERIAL_ADDER_CIN_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
`ifdef SERIAL_ADDER_CIN_EN
    logic             c_in;
`endif
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;

`ifdef SERIAL_ADDER_CIN_EN
    modport master (
        output start_in, a_in, b_in, c_in,
        input  busy_out, done_out, sum_out, carry_out
    );
    modport slave (
        input  start_in, a_in, b_in, c_in,
        output busy_out, done_out, sum_out, carry_out
    );
`else
    modport master (
        output start_in, a_in, b_in,
        input  busy_out, done_out, sum_out, carry_out
    );
    modport slave (
        input  start_in, a_in, b_in,
        output busy_out, done_out, sum_out, carry_out
    );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: one full-adder slice stepped LSB first over WIDTH cycles.
// Optional macro SERIAL_ADDER_CIN_EN adds an initial carry input (c_in) captured with the operands.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           clock,
    input  logic           reset,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             cy_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;

    logic             s_d;
    logic             cy_d;
    logic [WIDTH-1:0] res_d;
    logic             cin_d;

    // Full-adder slice on the current LSBs; sum bit enters the result from the top.
    always_comb begin
        s_d   = a_sh_q[0] ^ b_sh_q[0] ^ cy_q;
        cy_d  = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & cy_q) | (b_sh_q[0] & cy_q);
        res_d = {s_d, res_q[WIDTH-1:1]};
    end

`ifdef SERIAL_ADDER_CIN_EN
    assign cin_d = bus.c_in;
`else
    assign cin_d = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_in) begin
                        a_sh_q  <= bus.a_in;
                        b_sh_q  <= bus.b_in;
                        cy_q    <= cin_d;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    cy_q   <= cy_d;
                    res_q  <= res_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        carry_q <= cy_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_out  = busy_q;
    assign bus.done_out  = done_q;
    assign bus.sum_out   = sum_q;
    assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl (WIDTH=8), default build or with SERIAL_ADDER_CIN_EN.
module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_cin(input logic c);
`ifdef SERIAL_ADDER_CIN_EN
        bus.c_in = c;
`else
        if (c) begin end
`endif
    endtask

    // Present operands at a falling edge; returns at the falling edge after the capture edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        @(negedge clock);
        bus.start_in = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        set_cin(c);
        @(negedge clock);
        bus.start_in = 1'b0;
    endtask

    // Counts falling edges until done_out, bounded; records busy samples and the held result.
    task automatic wait_done(output int cycles, output int busy_cnt,
                             output logic [WIDTH-1:0] sum_run, output logic carry_run);
        cycles    = 0;
        busy_cnt  = 0;
        sum_run   = bus.sum_out;
        carry_run = bus.carry_out;
        while (!bus.done_out && cycles < 50) begin
            if (bus.busy_out) busy_cnt++;
            @(negedge clock);
            cycles++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_out); end
        checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done_out); end
        checks++; if (bus.sum_out !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", bus.sum_out); end
        checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", bus.carry_out); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int cyc, bc;
        logic [WIDTH-1:0] sr;
        logic cr;
        start_op(8'h5A, 8'h3C, 1'b0);
        wait_done(cyc, bc, sr, cr);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", cyc); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
        checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", bus.busy_out); end
        checks++; if (bus.sum_out !== 8'h96) begin errors++; $display("FAIL basic_sum: got %h want 96", bus.sum_out); end
        checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL basic_carry: got %b want 0", bus.carry_out); end
        @(negedge clock);
        checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", bus.done_out); end
    endtask

    task automatic test_overflow;
        int cyc, bc;
        logic [WIDTH-1:0] sr;
        logic cr;
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(cyc, bc, sr, cr);
        checks++; if (sr !== 8'h96) begin errors++; $display("FAIL ovf_hold_sum: got %h want 96", sr); end
        checks++; if (bus.sum_out !== 8'h00) begin errors++; $display("FAIL ovf_sum: got %h want 00", bus.sum_out); end
        checks++; if (bus.carry_out !== 1'b1) begin errors++; $display("FAIL ovf_carry: got %b want 1", bus.carry_out); end
        start_op(8'h00, 8'h00, 1'b0);
        wait_done(cyc, bc, sr, cr);
        checks++; if (cr !== 1'b1) begin errors++; $display("FAIL zero_hold_carry: got %b want 1", cr); end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL zero_latency: got %0d want 8", cyc); end
        checks++; if (bus.sum_out !== 8'h00) begin errors++; $display("FAIL zero_sum: got %h want 00", bus.sum_out); end
        checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL zero_carry: got %b want 0", bus.carry_out); end
    endtask

    task automatic test_ignore_start;
        int cyc, bc, dn;
        logic [WIDTH-1:0] sr;
        logic cr;
        start_op(8'h12, 8'h34, 1'b0);
        @(negedge clock);
        bus.start_in = 1'b1;
        bus.a_in     = 8'hFF;
        bus.b_in     = 8'hFF;
        @(negedge clock);
        bus.start_in = 1'b0;
        wait_done(cyc, bc, sr, cr);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL ign_latency: got %0d want 6", cyc); end
        checks++; if (bus.sum_out !== 8'h46) begin errors++; $display("FAIL ign_sum: got %h want 46", bus.sum_out); end
        checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL ign_carry: got %b want 0", bus.carry_out); end
        dn = 0;
        repeat (15) begin
            @(negedge clock);
            if (bus.done_out || bus.busy_out) dn++;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL ign_extra_activity: got %0d want 0", dn); end
    endtask

    task automatic test_reset_abort;
        int cyc, bc, dn;
        logic [WIDTH-1:0] sr;
        logic cr;
        start_op(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy_out); end
        checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", bus.done_out); end
        checks++; if (bus.sum_out !== 8'h00) begin errors++; $display("FAIL abort_sum: got %h want 00", bus.sum_out); end
        checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL abort_carry: got %b want 0", bus.carry_out); end
        reset = 1'b0;
        dn = 0;
        repeat (15) begin
            @(negedge clock);
            if (bus.done_out) dn++;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL abort_done_pulses: got %0d want 0", dn); end
        start_op(8'h0F, 8'h01, 1'b0);
        wait_done(cyc, bc, sr, cr);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL abort_restart_latency: got %0d want 8", cyc); end
        checks++; if (bus.sum_out !== 8'h10) begin errors++; $display("FAIL abort_restart_sum: got %h want 10", bus.sum_out); end
    endtask

    task automatic test_cin;
        int cyc, bc;
        logic [WIDTH-1:0] sr;
        logic cr;
        start_op(8'hFF, 8'h00, 1'b1);
        set_cin(1'b0);
        wait_done(cyc, bc, sr, cr);
`ifdef SERIAL_ADDER_CIN_EN
        checks++; if (bus.sum_out !== 8'h00) begin errors++; $display("FAIL cin_sum: got %h want 00", bus.sum_out); end
        checks++; if (bus.carry_out !== 1'b1) begin errors++; $display("FAIL cin_carry: got %b want 1", bus.carry_out); end
`else
        checks++; if (bus.sum_out !== 8'hFF) begin errors++; $display("FAIL nocin_sum: got %h want ff", bus.sum_out); end
        checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL nocin_carry: got %b want 0", bus.carry_out); end
`endif
    endtask

    task automatic test_back_to_back;
        int idx [$];
        @(negedge clock);
        bus.start_in = 1'b1;
        bus.a_in     = 8'h01;
        bus.b_in     = 8'h01;
        set_cin(1'b0);
        for (int i = 1; i <= 35; i++) begin
            @(negedge clock);
            if (bus.done_out) begin
                idx.push_back(i);
                checks++; if (bus.sum_out !== 8'h02) begin errors++; $display("FAIL b2b_sum: got %h want 02", bus.sum_out); end
            end
        end
        bus.start_in = 1'b0;
        checks++; if (idx.size() !== 3) begin errors++; $display("FAIL b2b_pulse_count: got %0d want 3", idx.size()); end
        if (idx.size() >= 1) begin
            checks++; if (idx[0] !== 9) begin errors++; $display("FAIL b2b_first_done: got %0d want 9", idx[0]); end
        end
        for (int i = 1; i < idx.size(); i++) begin
            checks++; if (idx[i] - idx[i-1] !== 10) begin errors++; $display("FAIL b2b_spacing: got %0d want 10", idx[i] - idx[i-1]); end
        end
        repeat (12) @(negedge clock);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.start_in = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        set_cin(1'b0);
        test_reset();
        test_basic();
        test_overflow();
        test_ignore_start();
        test_reset_abort();
        test_cin();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
